// File: rtl/blob_pkg.sv
// Shared types for the streaming blob labeller: FSM states, per-label
// statistics record and the arithmetic helpers that build and merge it.
package blob_pkg;

    localparam int AREA_W    = 17;
    localparam int SUM_X_W   = 26;
    localparam int SUM_Y_W   = 25;
    localparam int COORD_X_W = 11;
    localparam int COORD_Y_W = 10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACCUM   = 3'd1,
        ST_RESOLVE = 3'd2,
        ST_EMIT    = 3'd3,
        ST_DONE    = 3'd4
    } blob_state_e;

    typedef struct packed {
        logic [AREA_W-1:0]    area;
        logic [SUM_X_W-1:0]   sum_x;
        logic [SUM_Y_W-1:0]   sum_y;
        logic [COORD_X_W-1:0] x_min;
        logic [COORD_X_W-1:0] x_max;
        logic [COORD_Y_W-1:0] y_min;
        logic [COORD_Y_W-1:0] y_max;
    } blob_stats_t;

    // Empty record: minima start at all-ones so the first pixel always wins.
    function automatic blob_stats_t stats_clear();
        blob_stats_t s;
        s.area  = '0;
        s.sum_x = '0;
        s.sum_y = '0;
        s.x_min = '1;
        s.x_max = '0;
        s.y_min = '1;
        s.y_max = '0;
        return s;
    endfunction

    function automatic blob_stats_t stats_add_pixel(input blob_stats_t s,
                                                    input logic [COORD_X_W-1:0] x,
                                                    input logic [COORD_Y_W-1:0] y);
        blob_stats_t r;
        r.area  = s.area + AREA_W'(1);
        r.sum_x = s.sum_x + SUM_X_W'(x);
        r.sum_y = s.sum_y + SUM_Y_W'(y);
        r.x_min = (x < s.x_min) ? x : s.x_min;
        r.x_max = (x > s.x_max) ? x : s.x_max;
        r.y_min = (y < s.y_min) ? y : s.y_min;
        r.y_max = (y > s.y_max) ? y : s.y_max;
        return r;
    endfunction

    function automatic blob_stats_t stats_merge(input blob_stats_t a, input blob_stats_t b);
        blob_stats_t r;
        r.area  = a.area + b.area;
        r.sum_x = a.sum_x + b.sum_x;
        r.sum_y = a.sum_y + b.sum_y;
        r.x_min = (b.x_min < a.x_min) ? b.x_min : a.x_min;
        r.x_max = (b.x_max > a.x_max) ? b.x_max : a.x_max;
        r.y_min = (b.y_min < a.y_min) ? b.y_min : a.y_min;
        r.y_max = (b.y_max > a.y_max) ? b.y_max : a.y_max;
        return r;
    endfunction

endpackage

// File: rtl/label_line_buffer.sv
// One-row label memory: combinational read of the row above, one write per cycle.
module label_line_buffer #(
    parameter int WIDTH   = 320,
    parameter int LABEL_W = 5
) (
    input  logic               clk_in,
    input  logic               wr_en,
    input  logic [10:0]        wr_addr,
    input  logic [LABEL_W-1:0] wr_data,
    input  logic [10:0]        rd_addr,
    output logic [LABEL_W-1:0] rd_data
);

    localparam int AW = $clog2(WIDTH);
    localparam logic [10:0] ADDR_LIM = 11'(WIDTH);

    logic [LABEL_W-1:0] mem_r [0:WIDTH-1];

    // Store the current pixel's label so the next row sees it as its up neighbour.
    always_ff @(posedge clk_in) begin
        if (wr_en && (wr_addr < ADDR_LIM)) begin
            mem_r[wr_addr[AW-1:0]] <= wr_data;
        end
    end

    // Out-of-row addresses read as background.
    always_comb begin
        rd_data = '0;
        if (rd_addr < ADDR_LIM) begin
            rd_data = mem_r[rd_addr[AW-1:0]];
        end else begin
            rd_data = '0;
        end
    end

endmodule

// File: rtl/stream_blob_labeler.sv
// Single-pass connected-component labeller: labels a raster pixel stream,
// folds equivalent labels after the frame and emits per-blob statistics.
module stream_blob_labeler
    import blob_pkg::*;
#(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 180,
    parameter int MAX_LABELS = 16,
    parameter int MIN_AREA   = 20,
    parameter int LABEL_W    = $clog2(MAX_LABELS + 1)
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [10:0]        x_in,
    input  logic [9:0]         y_in,
    input  logic               mask_in,
    input  logic               valid_in,
    input  logic               new_frame_in,
    output logic               blob_valid_out,
    input  logic               blob_ready_in,
    output logic [LABEL_W-1:0] blob_label_out,
    output logic [16:0]        blob_area_out,
    output logic [25:0]        blob_sum_x_out,
    output logic [24:0]        blob_sum_y_out,
    output logic [10:0]        blob_x_min_out,
    output logic [10:0]        blob_x_max_out,
    output logic [9:0]         blob_y_min_out,
    output logic [9:0]         blob_y_max_out,
    output logic               busy_out,
    output logic               frame_done_out,
    output logic [LABEL_W-1:0] num_blobs_out,
    output logic               overflow_out
);

    localparam logic [10:0]        X_LAST     = 11'(WIDTH - 1);
    localparam logic [9:0]         Y_LAST     = 10'(HEIGHT - 1);
    localparam logic [LABEL_W-1:0] LBL_FULL   = LABEL_W'(MAX_LABELS + 1);
    localparam logic [LABEL_W-1:0] LBL_ONE    = LABEL_W'(1);
    localparam logic [AREA_W-1:0]  MIN_AREA_C = AREA_W'(MIN_AREA);

    blob_state_e        state_r;
    logic [LABEL_W-1:0] next_label_r;
    logic [LABEL_W-1:0] left_r;
    logic [LABEL_W-1:0] scan_r;
    logic [LABEL_W-1:0] parent_r [0:MAX_LABELS];
    blob_stats_t        stats_r  [0:MAX_LABELS];

    logic [LABEL_W-1:0] lb_rd_s, left_s, up_s, par_left_s, par_up_s;
    logic [LABEL_W-1:0] label_s, merge_hi_s, merge_lo_s, next_label_nxt_s, res_par_s;
    logic               alloc_s, exhaust_s, merge_s, start_s, pix_fire_s, last_pix_s, emit_ok_s;
    blob_stats_t        emit_stats_s;

    assign start_s    = new_frame_in && ((state_r == ST_IDLE) || (state_r == ST_ACCUM));
    assign pix_fire_s = (state_r == ST_ACCUM) && valid_in && !new_frame_in;
    assign last_pix_s = (x_in == X_LAST) && (y_in == Y_LAST);

    label_line_buffer #(
        .WIDTH   (WIDTH),
        .LABEL_W (LABEL_W)
    ) u_line_buf (
        .clk_in  (clk_in),
        .wr_en   (pix_fire_s),
        .wr_addr (x_in),
        .wr_data (label_s),
        .rd_addr (x_in),
        .rd_data (lb_rd_s)
    );

    // Label the incoming pixel from its left/up neighbours and detect merges.
    always_comb begin
        left_s     = '0;
        up_s       = '0;
        label_s    = '0;
        merge_hi_s = '0;
        merge_lo_s = '0;
        alloc_s    = 1'b0;
        exhaust_s  = 1'b0;
        merge_s    = 1'b0;
        if (x_in == 11'd0) left_s = '0; else left_s = left_r;
        if (y_in == 10'd0) up_s = '0;   else up_s = lb_rd_s;
        par_left_s = parent_r[left_s];
        par_up_s   = parent_r[up_s];
        if (!mask_in) begin
            label_s = '0;
        end else if ((left_s == '0) && (up_s == '0)) begin
            if (next_label_r == LBL_FULL) begin
                exhaust_s = 1'b1;
            end else begin
                label_s = next_label_r;
                alloc_s = 1'b1;
            end
        end else if (up_s == '0) begin
            label_s = left_s;
        end else if (left_s == '0) begin
            label_s = up_s;
        end else begin
            if (par_left_s < par_up_s) begin
                merge_lo_s = par_left_s;
                merge_hi_s = par_up_s;
            end else begin
                merge_lo_s = par_up_s;
                merge_hi_s = par_left_s;
            end
            label_s = merge_lo_s;
            merge_s = (par_left_s != par_up_s);
        end
        next_label_nxt_s = alloc_s ? (next_label_r + LBL_ONE) : next_label_r;
        res_par_s        = parent_r[scan_r];
        emit_stats_s     = stats_r[scan_r];
        emit_ok_s        = (res_par_s == scan_r) && (emit_stats_s.area >= MIN_AREA_C);
    end

    // Frame FSM: accumulate, fold equivalences, emit qualifying roots, report.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r        <= ST_IDLE;
            next_label_r   <= LBL_ONE;
            left_r         <= '0;
            scan_r         <= '0;
            for (int i = 0; i <= MAX_LABELS; i++) begin
                parent_r[i] <= LABEL_W'(i);
                stats_r[i]  <= stats_clear();
            end
            blob_valid_out <= 1'b0;
            blob_label_out <= '0;
            blob_area_out  <= '0;
            blob_sum_x_out <= '0;
            blob_sum_y_out <= '0;
            blob_x_min_out <= '0;
            blob_x_max_out <= '0;
            blob_y_min_out <= '0;
            blob_y_max_out <= '0;
            busy_out       <= 1'b0;
            frame_done_out <= 1'b0;
            num_blobs_out  <= '0;
            overflow_out   <= 1'b0;
        end else if (start_s) begin
            state_r        <= ST_ACCUM;
            next_label_r   <= LBL_ONE;
            left_r         <= '0;
            for (int i = 0; i <= MAX_LABELS; i++) begin
                parent_r[i] <= LABEL_W'(i);
                stats_r[i]  <= stats_clear();
            end
            blob_valid_out <= 1'b0;
            busy_out       <= 1'b1;
            frame_done_out <= 1'b0;
            num_blobs_out  <= '0;
            overflow_out   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_IDLE;
                end
                ST_ACCUM: begin
                    if (valid_in) begin
                        left_r       <= label_s;
                        next_label_r <= next_label_nxt_s;
                        if (exhaust_s) overflow_out <= 1'b1;
                        if (merge_s) parent_r[merge_hi_s] <= merge_lo_s;
                        if (label_s != '0) stats_r[label_s] <= stats_add_pixel(stats_r[label_s], x_in, y_in);
                        if (last_pix_s) begin
                            state_r <= ST_RESOLVE;
                            scan_r  <= next_label_nxt_s - LBL_ONE;
                        end
                    end
                end
                ST_RESOLVE: begin
                    if (scan_r == '0) begin
                        state_r <= ST_EMIT;
                        scan_r  <= LBL_ONE;
                    end else begin
                        if (res_par_s != scan_r) begin
                            stats_r[res_par_s] <= stats_merge(stats_r[res_par_s], stats_r[scan_r]);
                        end
                        scan_r <= scan_r - LBL_ONE;
                    end
                end
                ST_EMIT: begin
                    if (blob_valid_out) begin
                        if (blob_ready_in) begin
                            blob_valid_out <= 1'b0;
                            num_blobs_out  <= num_blobs_out + LBL_ONE;
                            scan_r         <= scan_r + LBL_ONE;
                        end
                    end else if (scan_r == next_label_r) begin
                        state_r        <= ST_DONE;
                        frame_done_out <= 1'b1;
                    end else if (emit_ok_s) begin
                        blob_valid_out <= 1'b1;
                        blob_label_out <= scan_r;
                        blob_area_out  <= emit_stats_s.area;
                        blob_sum_x_out <= emit_stats_s.sum_x;
                        blob_sum_y_out <= emit_stats_s.sum_y;
                        blob_x_min_out <= emit_stats_s.x_min;
                        blob_x_max_out <= emit_stats_s.x_max;
                        blob_y_min_out <= emit_stats_s.y_min;
                        blob_y_max_out <= emit_stats_s.y_max;
                    end else begin
                        scan_r <= scan_r + LBL_ONE;
                    end
                end
                ST_DONE: begin
                    frame_done_out <= 1'b0;
                    busy_out       <= 1'b0;
                    state_r        <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_blob_labeler.sv
// Scoreboard bench for stream_blob_labeler on a small 8x6 frame.
module tb_stream_blob_labeler;

    localparam int W    = 8;
    localparam int H    = 6;
    localparam int MAXL = 4;
    localparam int MINA = 3;
    localparam int LW   = 3;
    localparam int NPIX = W * H;

    typedef struct {
        int label; int area; int sx; int sy; int xmin; int xmax; int ymin; int ymax;
    } blob_t;
    typedef struct { int nb; int ovf; } fexp_t;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic [10:0]   x_in = '0;
    logic [9:0]    y_in = '0;
    logic          mask_in = 1'b0, valid_in = 1'b0, new_frame_in = 1'b0;
    logic          blob_ready_in = 1'b0;
    logic          blob_valid_out, busy_out, frame_done_out, overflow_out;
    logic [LW-1:0] blob_label_out, num_blobs_out;
    logic [16:0]   blob_area_out;
    logic [25:0]   blob_sum_x_out;
    logic [24:0]   blob_sum_y_out;
    logic [10:0]   blob_x_min_out, blob_x_max_out;
    logic [9:0]    blob_y_min_out, blob_y_max_out;

    int errors = 0, checks = 0, done_cnt = 0, xfer_cnt = 0;
    int ready_ctrl = 0;   // 0: always ready, 1: random, 2: manual
    blob_t exp_q[$];
    fexp_t fexp_q[$];

    stream_blob_labeler #(.WIDTH(W), .HEIGHT(H), .MAX_LABELS(MAXL), .MIN_AREA(MINA)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .x_in(x_in), .y_in(y_in), .mask_in(mask_in),
        .valid_in(valid_in), .new_frame_in(new_frame_in), .blob_valid_out(blob_valid_out),
        .blob_ready_in(blob_ready_in), .blob_label_out(blob_label_out),
        .blob_area_out(blob_area_out), .blob_sum_x_out(blob_sum_x_out),
        .blob_sum_y_out(blob_sum_y_out), .blob_x_min_out(blob_x_min_out),
        .blob_x_max_out(blob_x_max_out), .blob_y_min_out(blob_y_min_out),
        .blob_y_max_out(blob_y_max_out), .busy_out(busy_out), .frame_done_out(frame_done_out),
        .num_blobs_out(num_blobs_out), .overflow_out(overflow_out)
    );

    always #5 clk_in = ~clk_in;

    // Ready generator for the automatic modes.
    always @(posedge clk_in) begin
        #1;
        if (ready_ctrl == 0) blob_ready_in = 1'b1;
        else if (ready_ctrl == 1) blob_ready_in = ($urandom_range(0, 2) == 0);
    end

    function automatic bit blob_match(blob_t e);
        return (int'(blob_label_out) == e.label) && (int'(blob_area_out) == e.area) &&
               (int'(blob_sum_x_out) == e.sx) && (int'(blob_sum_y_out) == e.sy) &&
               (int'(blob_x_min_out) == e.xmin) && (int'(blob_x_max_out) == e.xmax) &&
               (int'(blob_y_min_out) == e.ymin) && (int'(blob_y_max_out) == e.ymax);
    endfunction

    task automatic show_fail(string name, blob_t e);
        $display("FAIL %s: got v=%0d lbl=%0d a=%0d sx=%0d sy=%0d x=%0d..%0d y=%0d..%0d, want lbl=%0d a=%0d sx=%0d sy=%0d x=%0d..%0d y=%0d..%0d",
                 name, blob_valid_out, blob_label_out, blob_area_out, blob_sum_x_out, blob_sum_y_out,
                 blob_x_min_out, blob_x_max_out, blob_y_min_out, blob_y_max_out,
                 e.label, e.area, e.sx, e.sy, e.xmin, e.xmax, e.ymin, e.ymax);
    endtask

    // Monitor: every accepted blob and every frame_done pulse is checked against the queues.
    always @(negedge clk_in) begin
        if (!rst_in) begin
            if (blob_valid_out && blob_ready_in) begin
                checks++;
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_blob: got lbl=%0d a=%0d, want none", blob_label_out, blob_area_out);
                end else begin
                    blob_t e;
                    e = exp_q.pop_front();
                    if (!blob_match(e)) begin
                        errors++;
                        show_fail("blob", e);
                    end
                end
            end
            if (frame_done_out) begin
                checks++;
                done_cnt++;
                if (fexp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: got frame_done=1, want 0");
                end else begin
                    fexp_t f;
                    f = fexp_q.pop_front();
                    if (int'(num_blobs_out) != f.nb || int'(overflow_out) != f.ovf || exp_q.size() != 0) begin
                        errors++;
                        $display("FAIL frame_done: got nb=%0d ovf=%0d pending=%0d, want nb=%0d ovf=%0d pending=0",
                                 num_blobs_out, overflow_out, exp_q.size(), f.nb, f.ovf);
                    end
                end
            end
        end
    end

    // Reference: whole-frame labelling with equivalence table, roots found by chasing parents.
    task automatic model_frame(input logic [NPIX-1:0] pat, input bit push_frame);
        int lab[NPIX];
        int par[MAXL+1];
        int ar[MAXL+1], sx[MAXL+1], sy[MAXL+1], xmn[MAXL+1], xmx[MAXL+1], ymn[MAXL+1], ymx[MAXL+1];
        int nl, nb, lf, up, a, b, r, i;
        bit ovf;
        nl = 1; nb = 0; ovf = 0;
        for (int l = 0; l <= MAXL; l++) begin
            par[l] = l; ar[l] = 0; sx[l] = 0; sy[l] = 0;
            xmn[l] = 9999; xmx[l] = -1; ymn[l] = 9999; ymx[l] = -1;
        end
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                i = y * W + x;
                lab[i] = 0;
                if (pat[i]) begin
                    lf = (x > 0) ? lab[i-1] : 0;
                    up = (y > 0) ? lab[i-W] : 0;
                    if (lf == 0 && up == 0) begin
                        if (nl > MAXL) ovf = 1;
                        else begin lab[i] = nl; nl++; end
                    end else if (lf == 0) lab[i] = up;
                    else if (up == 0) lab[i] = lf;
                    else begin
                        a = par[lf]; b = par[up];
                        lab[i] = (a < b) ? a : b;
                        if (a != b) par[(a > b) ? a : b] = lab[i];
                    end
                end
            end
        end
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                i = y * W + x;
                if (lab[i] != 0) begin
                    r = lab[i];
                    while (par[r] != r) r = par[r];
                    ar[r]++; sx[r] += x; sy[r] += y;
                    if (x < xmn[r]) xmn[r] = x;
                    if (x > xmx[r]) xmx[r] = x;
                    if (y < ymn[r]) ymn[r] = y;
                    if (y > ymx[r]) ymx[r] = y;
                end
            end
        end
        for (int l = 1; l < nl; l++) begin
            if (par[l] == l && ar[l] >= MINA) begin
                exp_q.push_back('{l, ar[l], sx[l], sy[l], xmn[l], xmx[l], ymn[l], ymx[l]});
                nb++;
            end
        end
        if (push_frame) fexp_q.push_back('{nb, int'(ovf)});
    endtask

    function automatic logic [NPIX-1:0] rect(int x0, int x1, int y0, int y1);
        logic [NPIX-1:0] p;
        p = '0;
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++) p[y*W+x] = 1'b1;
        return p;
    endfunction

    // Pulse new_frame_in, then stream the first npix pixels in raster order.
    task automatic start_frame(input logic [NPIX-1:0] pat, input bit gaps, input int npix);
        @(posedge clk_in); #1;
        new_frame_in = 1'b1; valid_in = 1'b0;
        @(posedge clk_in); #1;
        new_frame_in = 1'b0;
        for (int i = 0; i < npix; i++) begin
            for (int g = 0; g < 2 && gaps && $urandom_range(0, 3) == 0; g++) begin
                valid_in = 1'b0;
                x_in = 11'($urandom_range(0, 2047));
                mask_in = 1'($urandom_range(0, 1));
                @(posedge clk_in); #1;
            end
            valid_in = 1'b1;
            x_in = 11'(i % W); y_in = 10'(i / W); mask_in = pat[i];
            @(posedge clk_in); #1;
        end
        valid_in = 1'b0; mask_in = 1'b0;
    endtask

    task automatic wait_done(input int target);
        for (int c = 0; c < 3000 && done_cnt < target; c++) @(negedge clk_in);
        checks++;
        if (done_cnt < target) begin
            errors++;
            $display("FAIL done_timeout: got done_cnt=%0d, want %0d", done_cnt, target);
        end
    endtask

    task automatic wait_valid();
        for (int c = 0; c < 500 && !blob_valid_out; c++) @(negedge clk_in);
        checks++;
        if (!blob_valid_out) begin
            errors++;
            $display("FAIL valid_timeout: got blob_valid_out=0, want 1");
        end
    endtask

    logic [NPIX-1:0] pat_s;
    int d0, x0, dens;

    initial begin
        repeat (3) @(posedge clk_in);
        #1;
        checks++;
        if (blob_valid_out || busy_out || frame_done_out || overflow_out || num_blobs_out != 0 || blob_label_out != 0) begin
            errors++;
            $display("FAIL reset_state: got v=%0d busy=%0d done=%0d ovf=%0d nb=%0d, want all 0",
                     blob_valid_out, busy_out, frame_done_out, overflow_out, num_blobs_out);
        end
        rst_in = 1'b0;

        // 2x2 square.
        exp_q.push_back('{1, 4, 10, 6, 2, 3, 1, 2}); fexp_q.push_back('{1, 0});
        d0 = done_cnt; start_frame(rect(2, 3, 1, 2), 1'b0, NPIX); wait_done(d0 + 1);

        // U shape: labels 1 and 2 merge on the bottom row.
        exp_q.push_back('{1, 10, 25, 18, 1, 4, 0, 3}); fexp_q.push_back('{1, 0});
        d0 = done_cnt;
        start_frame(rect(1, 1, 0, 2) | rect(4, 4, 0, 2) | rect(1, 4, 3, 3), 1'b0, NPIX);
        wait_done(d0 + 1);

        // Isolated pixel is below MIN_AREA; only the bar is reported.
        exp_q.push_back('{2, 3, 9, 12, 2, 4, 4, 4}); fexp_q.push_back('{1, 0});
        d0 = done_cnt; start_frame(rect(6, 6, 0, 0) | rect(2, 4, 4, 4), 1'b0, NPIX); wait_done(d0 + 1);

        // Empty frame.
        fexp_q.push_back('{0, 0});
        d0 = done_cnt; start_frame('0, 1'b1, NPIX); wait_done(d0 + 1);

        // Five bars exhaust four labels.
        pat_s = rect(0, 2, 0, 0) | rect(4, 6, 0, 0) | rect(0, 2, 2, 2) | rect(4, 6, 2, 2) | rect(0, 2, 4, 4);
        model_frame(pat_s, 1'b0); fexp_q.push_back('{4, 1});
        d0 = done_cnt; start_frame(pat_s, 1'b0, NPIX); wait_done(d0 + 1);

        // Partial frame abandoned by a fresh new_frame_in, then a square.
        start_frame(rect(0, 7, 0, 5), 1'b0, 20);
        exp_q.push_back('{1, 4, 10, 6, 2, 3, 1, 2}); fexp_q.push_back('{1, 0});
        d0 = done_cnt; start_frame(rect(2, 3, 1, 2), 1'b0, NPIX); wait_done(d0 + 1);

        // Back-pressure: blob held for 5 cycles while frame inputs are ignored.
        ready_ctrl = 2; blob_ready_in = 1'b0;
        exp_q.push_back('{1, 4, 10, 6, 2, 3, 1, 2}); fexp_q.push_back('{1, 0});
        d0 = done_cnt; x0 = xfer_cnt;
        start_frame(rect(2, 3, 1, 2), 1'b0, NPIX);
        wait_valid();
        for (int k = 0; k < 5; k++) begin
            @(posedge clk_in); #1;
            new_frame_in = 1'b1; valid_in = 1'b1;
            @(negedge clk_in);
            checks++;
            if (!blob_valid_out || exp_q.size() == 0 || !blob_match(exp_q[0])) begin
                errors++;
                if (exp_q.size() != 0) show_fail("stall_hold", exp_q[0]);
                else $display("FAIL stall_hold: got empty queue, want pending blob");
            end
        end
        @(posedge clk_in); #1;
        new_frame_in = 1'b0; valid_in = 1'b0; blob_ready_in = 1'b1;
        wait_done(d0 + 1);
        checks++;
        if (xfer_cnt - x0 != 1) begin
            errors++;
            $display("FAIL stall_xfers: got %0d, want 1", xfer_cnt - x0);
        end

        // Reset in the middle of EMIT.
        blob_ready_in = 1'b0;
        exp_q.push_back('{1, 4, 10, 6, 2, 3, 1, 2}); fexp_q.push_back('{1, 0});
        start_frame(rect(2, 3, 1, 2), 1'b0, NPIX);
        wait_valid();
        @(posedge clk_in); #2;
        rst_in = 1'b1;
        #1;
        checks++;
        if (blob_valid_out || busy_out || frame_done_out || num_blobs_out != 0 || blob_area_out != 0) begin
            errors++;
            $display("FAIL reset_emit: got v=%0d busy=%0d done=%0d nb=%0d a=%0d, want all 0",
                     blob_valid_out, busy_out, frame_done_out, num_blobs_out, blob_area_out);
        end
        exp_q.delete(); fexp_q.delete();
        d0 = done_cnt;
        repeat (5) @(posedge clk_in);
        #1; rst_in = 1'b0; ready_ctrl = 0;
        repeat (10) @(posedge clk_in);
        #1;
        checks++;
        if (done_cnt != d0) begin
            errors++;
            $display("FAIL reset_no_done: got %0d pulses, want 0", done_cnt - d0);
        end
        exp_q.push_back('{1, 4, 10, 6, 2, 3, 1, 2}); fexp_q.push_back('{1, 0});
        d0 = done_cnt; start_frame(rect(2, 3, 1, 2), 1'b0, NPIX); wait_done(d0 + 1);

        // Random frames against the reference model.
        ready_ctrl = 1;
        for (int f = 0; f < 30; f++) begin
            dens = $urandom_range(10, 70);
            for (int i = 0; i < NPIX; i++) pat_s[i] = ($urandom_range(0, 99) < dens);
            model_frame(pat_s, 1'b1);
            d0 = done_cnt;
            start_frame(pat_s, 1'($urandom_range(0, 1)), NPIX);
            wait_done(d0 + 1);
        end

        repeat (5) @(posedge clk_in);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_blob_labeler.md
STREAM_BLOB_LABELER -- requirements
Module: stream_blob_labeler

Interface
REQ-001 Parameters SHALL be: WIDTH=320 (pixels/row); HEIGHT=180 (rows); MAX_LABELS=16 (provisional labels); MIN_AREA=20 (minimum emitted blob area); LABEL_W=$clog2(MAX_LABELS+1).
REQ-002 Ports SHALL be: clk_in input 1, sole clock; rst_in input 1, asynchronous active-high reset.
REQ-003 Pixel input ports SHALL be: x_in input 11, pixel column; y_in input 10, pixel row; mask_in input 1, foreground flag; valid_in input 1, pixel qualifier; new_frame_in input 1, frame-start strobe.
REQ-004 Blob output ports SHALL be: blob_valid_out output 1; blob_ready_in input 1; blob_label_out output LABEL_W; blob_area_out output 17; blob_sum_x_out output 26; blob_sum_y_out output 25; blob_x_min_out, blob_x_max_out output 11; blob_y_min_out, blob_y_max_out output 10.
REQ-005 Status ports SHALL be: busy_out output 1; frame_done_out output 1, one-cycle pulse; num_blobs_out output LABEL_W, count emitted; overflow_out output 1, label exhaustion in the last frame.

Function
REQ-006 The FSM SHALL have states IDLE, ACCUM, RESOLVE, EMIT, DONE.
REQ-007 IDLE -> ACCUM SHALL occur on new_frame_in; ACCUM entry SHALL clear all stats, set parent[i]=i, next_label=1, overflow_out=0, num_blobs_out=0.
REQ-008 In ACCUM, each valid_in pixel SHALL be labelled in raster order, one pixel per cycle, no stall.
REQ-009 Neighbours: left = label of the previous pixel in the row (0 when x_in==0); up = line-buffer entry at x_in (0 when y_in==0); 4-connectivity only.
REQ-010 Labelling rule: mask_in=0 -> 0; left=up=0 -> next_label, then next_label+1; one nonzero -> that label; both nonzero -> min(parent[left], parent[up]).
REQ-011 When parent[left] != parent[up], parent[max] SHALL be set to min in the same cycle; parent[i] <= i always holds.
REQ-012 When next_label == MAX_LABELS+1 and a new label is required, the pixel SHALL receive label 0 and overflow_out SHALL set and hold until the next ACCUM entry.
REQ-013 Each labelled nonzero pixel SHALL update its label's stats: area+1, sum_x+=x_in, sum_y+=y_in, and min/max of x and y; back-to-back same-label pixels SHALL accumulate correctly.
REQ-014 The line buffer SHALL be written with the pixel's label at x_in every valid_in cycle.
REQ-015 ACCUM -> RESOLVE SHALL occur on the cycle after the valid pixel at (WIDTH-1, HEIGHT-1).
REQ-016 new_frame_in during ACCUM SHALL discard the partial frame and re-enter ACCUM initialisation.
REQ-017 new_frame_in and valid_in SHALL be ignored in RESOLVE, EMIT and DONE.
REQ-018 RESOLVE SHALL visit labels from next_label-1 down to 1, one per cycle; each label with parent[i] != i SHALL fold its stats into parent[i] (sum areas/sums, min/max bounds) and mark itself non-root.
REQ-019 EMIT SHALL scan labels ascending, one per cycle; a root with area >= MIN_AREA SHALL be presented with blob_valid_out=1, held stable until blob_ready_in=1.
REQ-020 The scan SHALL advance on the handshake cycle; num_blobs_out SHALL increment per accepted blob; non-qualifying labels SHALL be skipped in one cycle each.
REQ-021 After the last label, DONE SHALL assert frame_done_out for one cycle and return to IDLE.
REQ-022 busy_out SHALL be 1 in ACCUM, RESOLVE, EMIT and DONE, and 0 in IDLE.
REQ-023 Zero-blob frames SHALL produce no blob_valid_out, then frame_done_out with num_blobs_out=0.

Reset
REQ-024 rst_in SHALL asynchronously force IDLE; all outputs to 0; next_label=1; line buffer contents don't-care.
REQ-025 rst_in mid-frame or mid-EMIT SHALL abort without emitting further blobs or frame_done_out.

Structure
REQ-026 Package blob_pkg SHALL hold the state enum, the blob-stats struct and the stat width constants, shared with downstream centroid logic.
REQ-027 The line buffer SHALL be one sub-module, label_line_buffer (WIDTH x LABEL_W, 1 read plus 1 write per cycle, register or BRAM).

Verification
REQ-028 Bench parameters SHALL be WIDTH=8, HEIGHT=6, MAX_LABELS=4, MIN_AREA=3.
REQ-029 2x2 square at (2..3, 1..2) -> one blob: label 1, area 4, sum_x 10, sum_y 6, bbox x2..3 y1..2, num_blobs 1.
REQ-030 U shape, columns x=1 and x=4 for rows 0..2, joined at row 3 x=1..4 -> labels 1 and 2 merge; one blob of area 10, label 1.
REQ-031 Single isolated pixel plus a 3-pixel bar -> only the bar is emitted (area 3); num_blobs 1.
REQ-032 Five isolated 3-pixel bars -> overflow_out=1; four blobs emitted; the fifth bar's pixels get label 0.
REQ-033 blob_ready_in held 0 for 5 cycles -> blob outputs stable throughout; then exactly one transfer.
REQ-034 rst_in asserted during EMIT -> outputs 0 next edge; no frame_done_out; a following frame labels correctly from label 1.
